// File: rtl/tl_d_queue.sv
// ---------------------------------------------------------------------------
// tl_d_queue
// Elastic buffer for the TileLink D (response) channel. It sits between a
// slave's D port and the client-side crossbar and fully decouples the two
// ready/valid handshakes. Depth, field widths and the optional pipe and flow
// bypass paths are set by parameters.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   io_enq_valid/ready      producer handshake
//   io_enq_bits_*           D fields: opcode, param, size, source, sink,
//                           denied, data, corrupt
//   io_deq_valid/ready      consumer handshake
//   io_deq_bits_*           head entry fields, same order and widths
//   io_count                current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module tl_d_queue #(
   parameter int DEPTH    = 2,
   parameter int DATA_W   = 64,
   parameter int SIZE_W   = 4,
   parameter int SOURCE_W = 5,
   parameter int SINK_W   = 3,
   parameter int PIPE     = 0,
   parameter int FLOW     = 0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         io_enq_valid,
   output logic                         io_enq_ready,
   input  logic [2:0]                   io_enq_bits_opcode,
   input  logic [1:0]                   io_enq_bits_param,
   input  logic [SIZE_W-1:0]            io_enq_bits_size,
   input  logic [SOURCE_W-1:0]          io_enq_bits_source,
   input  logic [SINK_W-1:0]            io_enq_bits_sink,
   input  logic                         io_enq_bits_denied,
   input  logic [DATA_W-1:0]            io_enq_bits_data,
   input  logic                         io_enq_bits_corrupt,
   input  logic                         io_deq_ready,
   output logic                         io_deq_valid,
   output logic [2:0]                   io_deq_bits_opcode,
   output logic [1:0]                   io_deq_bits_param,
   output logic [SIZE_W-1:0]            io_deq_bits_size,
   output logic [SOURCE_W-1:0]          io_deq_bits_source,
   output logic [SINK_W-1:0]            io_deq_bits_sink,
   output logic                         io_deq_bits_denied,
   output logic [DATA_W-1:0]            io_deq_bits_data,
   output logic                         io_deq_bits_corrupt,
   output logic [$clog2(DEPTH+1)-1:0]   io_count
);

   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam bit PIPE_EN = (PIPE != 0);
   localparam bit FLOW_EN = (FLOW != 0);

   // Declaration order puts opcode at the least significant bits.
   typedef struct packed {
      logic                corrupt;
      logic [DATA_W-1:0]   data;
      logic                denied;
      logic [SINK_W-1:0]   sink;
      logic [SOURCE_W-1:0] source;
      logic [SIZE_W-1:0]   size;
      logic [1:0]          param;
      logic [2:0]          opcode;
   } entry_t;

   entry_t           r_ram [DEPTH];
   logic [PTR_W-1:0] r_enqPtr;
   logic [PTR_W-1:0] r_deqPtr;
   logic             r_maybeFull;

   entry_t           w_enqEntry;
   entry_t           w_deqEntry;
   logic             w_ptrMatch;
   logic             w_empty;
   logic             w_full;
   logic             w_doEnq;
   logic             w_doDeq;
   logic             w_bypass;
   logic             w_push;
   logic             w_pop;
   logic [PTR_W:0]   w_ptrDiff;
   logic [PTR_W:0]   w_ptrDist;

   // Wraps from DEPTH-1 to 0 so that depths that are not a power of two
   // never index past the end of the array.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Pack the incoming beat into one storage word.
   always_comb begin
      w_enqEntry         = '0;
      w_enqEntry.opcode  = io_enq_bits_opcode;
      w_enqEntry.param   = io_enq_bits_param;
      w_enqEntry.size    = io_enq_bits_size;
      w_enqEntry.source  = io_enq_bits_source;
      w_enqEntry.sink    = io_enq_bits_sink;
      w_enqEntry.denied  = io_enq_bits_denied;
      w_enqEntry.data    = io_enq_bits_data;
      w_enqEntry.corrupt = io_enq_bits_corrupt;
   end

   // Equal pointers are ambiguous on their own; maybe_full records whether
   // the last pointer-changing operation was a write, which tells full from
   // empty. The pipe path lets a full queue accept when the head is leaving,
   // and the flow path lets an empty queue present the incoming beat.
   always_comb begin
      w_ptrMatch   = (r_enqPtr == r_deqPtr);
      w_empty      = w_ptrMatch & ~r_maybeFull;
      w_full       = w_ptrMatch & r_maybeFull;
      io_enq_ready = ~w_full | (PIPE_EN & io_deq_ready);
      io_deq_valid = ~w_empty | (FLOW_EN & io_enq_valid);
      w_doEnq      = io_enq_valid & io_enq_ready;
      w_doDeq      = io_deq_valid & io_deq_ready;
      // A beat that flows straight through an empty queue never touches the
      // storage, so the write and both pointer moves are suppressed.
      w_bypass     = FLOW_EN & w_empty & io_deq_ready;
      w_push       = w_doEnq & ~w_bypass;
      w_pop        = w_doDeq & ~w_bypass;
   end

   // Head entry is read combinationally; when flowing through an empty
   // queue the enq fields are forwarded instead.
   always_comb begin
      w_deqEntry = r_ram[r_deqPtr];
      if (FLOW_EN && w_empty) begin
         w_deqEntry = w_enqEntry;
      end
      io_deq_bits_opcode  = w_deqEntry.opcode;
      io_deq_bits_param   = w_deqEntry.param;
      io_deq_bits_size    = w_deqEntry.size;
      io_deq_bits_source  = w_deqEntry.source;
      io_deq_bits_sink    = w_deqEntry.sink;
      io_deq_bits_denied  = w_deqEntry.denied;
      io_deq_bits_data    = w_deqEntry.data;
      io_deq_bits_corrupt = w_deqEntry.corrupt;
   end

   // Occupancy: pointer distance modulo DEPTH, with DEPTH added back when
   // the raw difference goes negative. Equal pointers mean 0 or DEPTH.
   always_comb begin
      w_ptrDiff = {1'b0, r_enqPtr} - {1'b0, r_deqPtr};
      w_ptrDist = w_ptrDiff;
      if (w_ptrDiff[PTR_W]) begin
         w_ptrDist = w_ptrDiff + (PTR_W+1)'(DEPTH);
      end
      if (w_ptrMatch) begin
         io_count = r_maybeFull ? CNT_W'(DEPTH) : '0;
      end else begin
         io_count = CNT_W'(w_ptrDist);
      end
   end

   // Pointer and full-flag state. Reset empties the queue immediately; the
   // stored words are left as they are because they are unreachable once
   // both pointers are zero and maybe_full is clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_enqPtr    <= '0;
         r_deqPtr    <= '0;
         r_maybeFull <= 1'b0;
      end else begin
         if (w_push) begin
            r_enqPtr <= nextPtr(r_enqPtr);
         end
         if (w_pop) begin
            r_deqPtr <= nextPtr(r_deqPtr);
         end
         if (w_push != w_pop) begin
            r_maybeFull <= w_push;
         end
      end
   end

   // Storage array, written at the enqueue pointer. When full in pipe mode
   // this overwrites the slot being dequeued in the same cycle; the reader
   // still sees the old word until the edge.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_ram[r_enqPtr] <= w_enqEntry;
      end
   end

endmodule
